rng_chaos_stream: RTL and testbench
===================================

Name: rng_chaos_stream

Overview:
Parametrised successor to the fixed 32-bit chaotic RNG core. It holds a fixed-point Lorenz-system iterator of configurable width, precision and step size, with runtime seeding and an enable. A warm-up discard counter and decimation (one sample per N iterations) sit after the iterator. The XOR-folded sample feeds a DEPTH-entry FIFO drained through a valid/ready stream; raw x/y/z stay exported for logic-analyzer and IO hookup in the caravel user-area top.

Parameters:
WIDTH, 32, state/sample width in bits, signed two's complement
FRAC, 16, fractional bits of the Q format
DT_SHIFT, 8, Euler step dt = 2^-DT_SHIFT
ITER_PER_SAMPLE, 1, iterations between FIFO pushes (>=1)
WARMUP, 0, iterations discarded after reset/seed load before the first push
DEPTH, 8, FIFO entries (power of 2, >=2)
SEED_X, 32'h0001_0000, reset value of x (1.0 in Q16.16)
SEED_Y, 32'h0001_0000, reset value of y
SEED_Z, 32'h0001_0000, reset value of z

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  run iterator: 1 = one Euler step per cycle
seed_load_i  in  1  single-cycle pulse: load seeds, flush FIFO, restart warm-up
seed_x_i  in  WIDTH  seed for x
seed_y_i  in  WIDTH  seed for y
seed_z_i  in  WIDTH  seed for z
out_valid_o  out  1  FIFO non-empty
out_ready_i  in  1  consumer pop
out_data_o  out  WIDTH  FIFO head (first-word fall-through)
level_o  out  $clog2(DEPTH+1)  FIFO occupancy
drop_cnt_o  out  16  samples lost to a full FIFO; saturates at 16'hFFFF
warm_o  out  1  high once warm-up is complete
x_o, y_o, z_o  out  WIDTH each  current state registers

Behaviour:
- Reset (async assert, sync release):
  - x/y/z = SEED_X/Y/Z
  - FIFO empty, out_valid_o=0, level_o=0, drop_cnt_o=0
  - warm-up counter=0; warm_o = (WARMUP==0)
  - decimation counter=0
- Step, evaluated at 2*WIDTH precision:
  - dx = 10*(y-x)
  - dy = ((x*(RHO_Q-z))>>>FRAC) - y
  - dz = ((x*y)>>>FRAC) - ((BETA_Q*z)>>>FRAC)
  - x' = x + (dx>>>DT_SHIFT), likewise y' and z'
  - Truncate to WIDTH with wrap-around, no saturation; all shifts arithmetic (floor).
- Iteration: with enable_i=1 and seed_load_i=0, the state registers take x'/y'/z' at each rising edge.
- Warm-up: counts iterations up to WARMUP; warm_o rises on the edge completing iteration WARMUP.
- Decimation: once warm, the decimation counter counts iterations 0..ITER_PER_SAMPLE-1.
- Push: on the iteration that wraps the decimation counter, sample = x'^y'^z' is pushed at that same edge.
- Latency: enable_i high in cycle 0 (warm, N=1) -> push at end of cycle 0 -> out_valid_o=1 and out_data_o=sample in cycle 1.
- Pop: out_valid_o & out_ready_i at an edge removes the head; the next entry, if any, is visible the following cycle.
- Full: a push with no simultaneous pop is dropped and drop_cnt_o increments (saturating). The iterator never stalls.
- Push and pop in the same cycle:
  - When full: both are accepted, level unchanged.
  - When empty: the push is stored and the pop is ignored, since out_valid_o was 0.
- seed_load_i has priority over enable_i. At that edge:
  - state loaded from seed_*_i
  - FIFO flushed, drop_cnt_o cleared
  - warm-up and decimation counters cleared
  - no push occurs
- enable_i=0: state, counters and FIFO write side are frozen; pops still work.
- Reset mid-operation returns everything to the reset values immediately (asynchronous).

Decomposition:
- Package rng_chaos_pkg holds:
  - RHO_Q = 28<<FRAC
  - BETA_Q = round(8/3 * 2^FRAC), i.e. 32'h0002_AAAB at FRAC=16
  - SIGMA = 10
  - a localparam helper for the level width
- Sub-module rng_sync_fifo (WIDTH, DEPTH; first-word fall-through, level output). The iterator, warm-up and decimation logic stay in rng_chaos_stream.

Test Plan:
- Default parameters; release reset, enable 1 cycle -> x_o=32'h0001_0000, y_o=32'h0001_1A00, z_o=32'h0000_FE55; next cycle out_valid_o=1, out_data_o=32'h0000_E455, level_o=1.
- out_ready_i=0, enable held 12 cycles, DEPTH=8 -> level_o=8, drop_cnt_o=4, iterator keeps changing x_o/y_o/z_o.
- Full FIFO, enable=1 and out_ready_i=1 for 5 cycles -> level_o stays 8, drop_cnt_o unchanged, data popped in push order against a reference model.
- WARMUP=3, ITER_PER_SAMPLE=2 -> warm_o rises after iteration 3; first push after iteration 5; pushes then every 2nd iteration.
- Seed load of (0,0,0) mid-stream with FIFO holding 5 -> next cycle level_o=0, drop_cnt_o=0; enabled state stays 0 forever (fixed point); pushes are 32'h0.
- Assert rst_ni low mid-cycle while full -> out_valid_o, level_o and drop_cnt_o drop to 0 without a clock edge; state returns to SEED_*.

Source files
------------

// File: rtl/rng_chaos_pkg.sv
// Shared constants and helpers for the chaotic RNG stream block.
// The Lorenz constants are functions of the Q-format fraction width so every user shares one definition.
package rng_chaos_pkg;

  localparam int SIGMA = 10;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic longint rho_q(input int frac);
    return 64'sd28 <<< frac;
  endfunction

  // 8/3 rounded to nearest in Q(frac): (16*2^frac + 3) / 6
  function automatic longint beta_q(input int frac);
    return ((64'sd16 <<< frac) + 64'sd3) / 64'sd6;
  endfunction

  localparam longint RHO_Q  = rho_q(16);
  localparam longint BETA_Q = beta_q(16);

endpackage

// File: rtl/rng_chaos_stream_if.sv
// Valid/ready sample stream leaving the RNG; the producer drives valid/data.
interface rng_chaos_stream_if #(
  parameter int WIDTH = 32
) ();
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  modport master (output out_valid_o, output out_data_o, input out_ready_i);
  modport slave  (input out_valid_o, input out_data_o, output out_ready_i);
endinterface

// File: rtl/rng_sync_fifo.sv
// First-word fall-through FIFO with flush and occupancy output.
// A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
module rng_sync_fifo
  import rng_chaos_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [lvl_w(DEPTH)-1:0]  o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [LW-1:0]    r_cnt;
  logic             w_pop, w_push;

  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == LW'(DEPTH));
  assign w_pop   = i_pop & o_valid & ~i_flush;
  assign w_push  = i_push & (~o_full | w_pop) & ~i_flush;
  assign o_data  = r_mem[r_rp];
  assign o_level = r_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + LW'(1);
        2'b01:   r_cnt <= r_cnt - LW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rng_chaos_stream.sv
// Fixed-point Lorenz iterator with warm-up discard, decimation and a sample FIFO.
// Each enabled cycle performs one Euler step; the folded sample x'^y'^z' feeds the FIFO.
module rng_chaos_stream
  import rng_chaos_pkg::*;
#(
  parameter int               WIDTH           = 32,
  parameter int               FRAC            = 16,
  parameter int               DT_SHIFT        = 8,
  parameter int               ITER_PER_SAMPLE = 1,
  parameter int               WARMUP          = 0,
  parameter int               DEPTH           = 8,
  parameter logic [WIDTH-1:0] SEED_X          = WIDTH'(32'h0001_0000),
  parameter logic [WIDTH-1:0] SEED_Y          = WIDTH'(32'h0001_0000),
  parameter logic [WIDTH-1:0] SEED_Z          = WIDTH'(32'h0001_0000)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     seed_load_i,
  input  logic [WIDTH-1:0]         seed_x_i,
  input  logic [WIDTH-1:0]         seed_y_i,
  input  logic [WIDTH-1:0]         seed_z_i,
  rng_chaos_stream_if.master       strm,
  output logic [lvl_w(DEPTH)-1:0]  level_o,
  output logic [15:0]              drop_cnt_o,
  output logic                     warm_o,
  output logic [WIDTH-1:0]         x_o,
  output logic [WIDTH-1:0]         y_o,
  output logic [WIDTH-1:0]         z_o
);
  localparam int W2  = 2 * WIDTH;
  localparam int WCW = $clog2(WARMUP + 2);
  localparam int DCW = $clog2(ITER_PER_SAMPLE + 1);
  typedef logic signed [W2-1:0] wide_t;
  localparam wide_t RHO_W   = W2'(rho_q(FRAC));
  localparam wide_t BETA_W  = W2'(beta_q(FRAC));
  localparam wide_t SIGMA_W = W2'(SIGMA);

  logic signed [WIDTH-1:0] r_x, r_y, r_z;
  logic signed [WIDTH-1:0] w_xn, w_yn, w_zn;
  wide_t                   w_xe, w_ye, w_ze, w_dx, w_dy, w_dz;
  logic [WCW-1:0]          r_wcnt;
  logic [DCW-1:0]          r_dcnt;
  logic [15:0]             r_drop;
  logic                    w_step, w_warm, w_wrap, w_push, w_full, w_valid, w_drop;
  logic [WIDTH-1:0]        w_sample;

  // Full-precision Euler step; the final casts wrap back to WIDTH.
  always_comb begin
    w_xe = W2'(r_x);
    w_ye = W2'(r_y);
    w_ze = W2'(r_z);
    w_dx = SIGMA_W * (w_ye - w_xe);
    w_dy = ((w_xe * (RHO_W - w_ze)) >>> FRAC) - w_ye;
    w_dz = ((w_xe * w_ye) >>> FRAC) - ((BETA_W * w_ze) >>> FRAC);
    w_xn = WIDTH'(w_xe + (w_dx >>> DT_SHIFT));
    w_yn = WIDTH'(w_ye + (w_dy >>> DT_SHIFT));
    w_zn = WIDTH'(w_ze + (w_dz >>> DT_SHIFT));
  end

  assign w_step   = enable_i & ~seed_load_i;
  assign w_warm   = (r_wcnt == WCW'(WARMUP));
  assign w_wrap   = (r_dcnt == DCW'(ITER_PER_SAMPLE - 1));
  assign w_push   = w_step & w_warm & w_wrap;
  assign w_sample = w_xn ^ w_yn ^ w_zn;
  assign w_drop   = w_push & w_full & ~(strm.out_ready_i & w_valid);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x <= SEED_X;
      r_y <= SEED_Y;
      r_z <= SEED_Z;
    end else if (seed_load_i) begin
      r_x <= seed_x_i;
      r_y <= seed_y_i;
      r_z <= seed_z_i;
    end else if (enable_i) begin
      r_x <= w_xn;
      r_y <= w_yn;
      r_z <= w_zn;
    end
  end

  // Warm-up counts only until it saturates at WARMUP; decimation runs only once warm.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wcnt <= '0;
      r_dcnt <= '0;
    end else if (seed_load_i) begin
      r_wcnt <= '0;
      r_dcnt <= '0;
    end else if (enable_i) begin
      if (!w_warm)     r_wcnt <= r_wcnt + WCW'(1);
      else if (w_wrap) r_dcnt <= '0;
      else             r_dcnt <= r_dcnt + DCW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         r_drop <= '0;
    else if (seed_load_i)                r_drop <= '0;
    else if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
  end

  rng_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_flush (seed_load_i),
    .i_push  (w_push),
    .i_pop   (strm.out_ready_i),
    .i_data  (w_sample),
    .o_data  (strm.out_data_o),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_level (level_o)
  );

  assign strm.out_valid_o = w_valid;
  assign drop_cnt_o       = r_drop;
  assign warm_o           = w_warm;
  assign x_o              = r_x;
  assign y_o              = r_y;
  assign z_o              = r_z;

endmodule

// File: tb/tb_rng_chaos_stream.sv
// Bench: two instances (default, and WARMUP=3/ITER_PER_SAMPLE=2) driven by shared stimulus,
// each compared every cycle against an arithmetic Lorenz + FIFO reference model.
module tb_rng_chaos_stream;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, ld = 1'b0, rdy = 1'b0;
  logic [31:0] sx = '0, sy = '0, sz = '0;
  logic [3:0]  lvl1, lvl2;
  logic [15:0] drop1, drop2;
  logic        warm1, warm2;
  logic [31:0] x1, y1, z1, x2, y2, z2;

  rng_chaos_stream_if #(.WIDTH(32)) s1 ();
  rng_chaos_stream_if #(.WIDTH(32)) s2 ();
  assign s1.out_ready_i = rdy;
  assign s2.out_ready_i = rdy;

  rng_chaos_stream dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .seed_load_i(ld),
    .seed_x_i(sx), .seed_y_i(sy), .seed_z_i(sz), .strm(s1),
    .level_o(lvl1), .drop_cnt_o(drop1), .warm_o(warm1), .x_o(x1), .y_o(y1), .z_o(z1));

  rng_chaos_stream #(.WARMUP(3), .ITER_PER_SAMPLE(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .seed_load_i(ld),
    .seed_x_i(sx), .seed_y_i(sy), .seed_z_i(sz), .strm(s2),
    .level_o(lvl2), .drop_cnt_o(drop2), .warm_o(warm2), .x_o(x2), .y_o(y2), .z_o(z2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x, y, z;
    int wcnt, dcnt, drop, head, cnt;
    logic [7:0][31:0] q;
  } mdl_t;

  typedef struct {
    bit en, rdy;
    int lvl, drop, lvl2;
    bit warm2;
  } vec_t;

  mdl_t m1, m2;
  int   tests = 0, fails = 0;
  vec_t tbl[17];

  function automatic mdl_t mreset();
    mdl_t m;
    m = '0;
    m.x = 32'h0001_0000; m.y = 32'h0001_0000; m.z = 32'h0001_0000;
    return m;
  endfunction

  // Lorenz Euler step in Q16.16 (sigma 10, rho 28, beta 8/3 ~ 174763), dt = 1/256, 64-bit then wrap.
  function automatic mdl_t mstep(mdl_t mi, bit e, bit l, bit r, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] c, int warmup, int nper);
    mdl_t m;
    longint xs, ys, zs, dx, dy, dz;
    logic [31:0] nx, ny, nz;
    bit push;
    m = mi;
    if (l) begin
      m.x = a; m.y = b; m.z = c;
      m.cnt = 0; m.head = 0; m.drop = 0; m.wcnt = 0; m.dcnt = 0;
      return m;
    end
    if (r && m.cnt > 0) begin m.head = (m.head + 1) % 8; m.cnt = m.cnt - 1; end
    if (!e) return m;
    xs = longint'(signed'(m.x)); ys = longint'(signed'(m.y)); zs = longint'(signed'(m.z));
    dx = 10 * (ys - xs);
    dy = ((xs * (longint'(28 * 65536) - zs)) >>> 16) - ys;
    dz = ((xs * ys) >>> 16) - ((longint'(174763) * zs) >>> 16);
    nx = 32'(xs + (dx >>> 8));
    ny = 32'(ys + (dy >>> 8));
    nz = 32'(zs + (dz >>> 8));
    push = 1'b0;
    if (m.wcnt < warmup) m.wcnt = m.wcnt + 1;
    else begin
      push = (m.dcnt == nper - 1);
      m.dcnt = push ? 0 : m.dcnt + 1;
    end
    if (push) begin
      if (m.cnt < 8) begin m.q[(m.head + m.cnt) % 8] = nx ^ ny ^ nz; m.cnt = m.cnt + 1; end
      else if (m.drop < 65535) m.drop = m.drop + 1;
    end
    m.x = nx; m.y = ny; m.z = nz;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string t, input mdl_t m, input int warmup, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] z, input logic v, input logic [31:0] d,
                     input logic [3:0] l, input logic [15:0] dr, input logic w);
    chk({t, "_x"}, 64'(x), 64'(m.x));
    chk({t, "_y"}, 64'(y), 64'(m.y));
    chk({t, "_z"}, 64'(z), 64'(m.z));
    chk({t, "_valid"}, 64'(v), 64'(m.cnt > 0));
    chk({t, "_level"}, 64'(l), 64'(m.cnt));
    chk({t, "_drop"}, 64'(dr), 64'(m.drop));
    chk({t, "_warm"}, 64'(w), 64'(m.wcnt >= warmup));
    if (m.cnt > 0) chk({t, "_data"}, 64'(d), 64'(m.q[m.head]));
  endtask

  task automatic cmp_all();
    cmp("d1", m1, 0, x1, y1, z1, s1.out_valid_o, s1.out_data_o, lvl1, drop1, warm1);
    cmp("d2", m2, 3, x2, y2, z2, s2.out_valid_o, s2.out_data_o, lvl2, drop2, warm2);
  endtask

  task automatic cyc(input bit e, input bit l, input bit r, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c);
    en = e; ld = l; rdy = r; sx = a; sy = b; sz = c;
    @(posedge clk);
    m1 = mstep(m1, e, l, r, a, b, c, 0, 1);
    m2 = mstep(m2, e, l, r, a, b, c, 3, 2);
    #1;
    cmp_all();
  endtask

  initial begin
    // {en, rdy, dut level, dut drops, dut2 level, dut2 warm} after each edge
    tbl[0]  = '{1, 0, 1, 0, 0, 0};  tbl[1]  = '{1, 0, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 3, 0, 0, 1};  tbl[3]  = '{1, 0, 4, 0, 0, 1};
    tbl[4]  = '{1, 0, 5, 0, 1, 1};  tbl[5]  = '{1, 0, 6, 0, 1, 1};
    tbl[6]  = '{1, 0, 7, 0, 2, 1};  tbl[7]  = '{1, 0, 8, 0, 2, 1};
    tbl[8]  = '{1, 0, 8, 1, 3, 1};  tbl[9]  = '{1, 0, 8, 2, 3, 1};
    tbl[10] = '{1, 0, 8, 3, 4, 1};  tbl[11] = '{1, 0, 8, 4, 4, 1};
    tbl[12] = '{1, 1, 8, 4, 4, 1};  tbl[13] = '{1, 1, 8, 4, 3, 1};
    tbl[14] = '{1, 1, 8, 4, 3, 1};  tbl[15] = '{1, 1, 8, 4, 2, 1};
    tbl[16] = '{1, 1, 8, 4, 2, 1};

    m1 = mreset(); m2 = mreset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    chk("rst_warm1", 64'(warm1), 64'd1);
    chk("rst_warm2", 64'(warm2), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].en, 1'b0, tbl[i].rdy, '0, '0, '0);
      chk($sformatf("tbl%0d_lvl", i), 64'(lvl1), 64'(tbl[i].lvl));
      chk($sformatf("tbl%0d_drop", i), 64'(drop1), 64'(tbl[i].drop));
      chk($sformatf("tbl%0d_lvl2", i), 64'(lvl2), 64'(tbl[i].lvl2));
      chk($sformatf("tbl%0d_warm2", i), 64'(warm2), 64'(tbl[i].warm2));
      if (i == 0) begin
        chk("step1_x", 64'(x1), 64'h0001_0000);
        chk("step1_y", 64'(y1), 64'h0001_1A00);
        chk("step1_z", 64'(z1), 64'h0000_FE55);
        chk("step1_valid", 64'(s1.out_valid_o), 64'd1);
        chk("step1_data", 64'(s1.out_data_o), 64'h0000_E455);
      end
    end

    // Drain to 5 entries with the iterator frozen, then seed the zero fixed point.
    repeat (3) cyc(1'b0, 1'b0, 1'b1, '0, '0, '0);
    chk("drain_lvl", 64'(lvl1), 64'd5);
    cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
    chk("seed_lvl", 64'(lvl1), 64'd0);
    chk("seed_drop", 64'(drop1), 64'd0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0, '0, '0, '0);
    chk("zero_x", 64'(x1), 64'd0);
    chk("zero_z", 64'(z1), 64'd0);
    chk("zero_data", 64'(s1.out_data_o), 64'd0);
    chk("zero_lvl", 64'(lvl1), 64'd6);

    // Random traffic with occasional reseeds.
    for (int i = 0; i < 400; i++) begin
      automatic bit l = ($urandom_range(0, 39) == 0);
      cyc(1'($urandom_range(0, 3) != 0), l, 1'($urandom_range(0, 1)),
          $urandom_range(0, 32'h0004_0000), $urandom_range(0, 32'h0004_0000),
          $urandom_range(0, 32'h0004_0000));
    end

    // Refill from default seeds, then assert reset mid-cycle.
    cyc(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, '0, '0, '0);
    chk("pre_rst_lvl", 64'(lvl1), 64'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(s1.out_valid_o), 64'd0);
    chk("async_lvl", 64'(lvl1), 64'd0);
    chk("async_drop", 64'(drop1), 64'd0);
    chk("async_x", 64'(x1), 64'h0001_0000);
    chk("async_y", 64'(y1), 64'h0001_0000);
    m1 = mreset(); m2 = mreset();
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
